srl_seq_checker: RTL and testbench

SRL_SEQ_CHECKER -- requirements
Module: srl_seq_checker

---
 rtl/srl_seq_checker.sv | 131 +++++++++++++
 tb/tb_srl_seq_checker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/srl_seq_checker.sv
// Drives NUM_SRL SRL32 lanes with LFSR data, reads every address back each pass
// and flags per-lane mismatches against a shadow copy of the expected contents.
module srl_seq_checker #(
  parameter int                    NUM_SRL   = 8,
  parameter logic [NUM_SRL*32-1:0] INIT_VEC  = {NUM_SRL{32'h5A5A_C3C3}},
  parameter int                    SHIFT_LEN = 7,
  parameter int                    READ_LAT  = 1,
  parameter logic [15:0]           LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               srl_ce,
  output logic [NUM_SRL-1:0] srl_d,
  output logic [4:0]         srl_a,
  input  logic [NUM_SRL-1:0] srl_q,
  output logic [NUM_SRL-1:0] error,
  output logic               pass_done,
  output logic [7:0]         pass_cnt
);

  typedef enum logic [1:0] {IDLE, CHECK, DRAIN, SHIFT} state_t;

  state_t     state;
  logic [4:0] cnt;

  // Shadow and LFSR mirror physical SRLs: power-up contents only, untouched by rst_n.
  logic [NUM_SRL-1:0][31:0] shadow = INIT_VEC;
  logic [15:0]              lfsr   = LFSR_SEED;
  logic                     fb;

  logic                issue_v;
  logic [4:0]          issue_a;
  logic [READ_LAT-1:0] valid_pipe;
  logic [4:0]          addr_pipe [READ_LAT];

  assign fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign srl_d = lfsr[NUM_SRL-1:0];

  // Address loaded into srl_a on this edge, tagged valid only when it is a CHECK read.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    issue_v = 1'b0;
    issue_a = 5'd0;
    case (state)
      IDLE:    issue_v = en;
      CHECK: begin
        issue_v = (srl_a != 5'd31);
        issue_a = srl_a + 5'd1;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      srl_ce     <= 1'b0;
      srl_a      <= 5'd0;
      error      <= '0;
      pass_done  <= 1'b0;
      pass_cnt   <= 8'd0;
      valid_pipe <= '0;
    end else begin
      pass_done     <= 1'b0;
      valid_pipe[0] <= issue_v;
      for (int k = 1; k < READ_LAT; k++) valid_pipe[k] <= valid_pipe[k-1];

      if (valid_pipe[READ_LAT-1]) begin
        for (int i = 0; i < NUM_SRL; i++) begin
          if (srl_q[i] != shadow[i][addr_pipe[READ_LAT-1]]) error[i] <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (en) begin
            state <= CHECK;
            srl_a <= 5'd0;
          end
        end
        CHECK: begin
          if (srl_a == 5'd31) begin
            state <= DRAIN;
            cnt   <= 5'd0;
          end else begin
            srl_a <= srl_a + 5'd1;
          end
        end
        // Hold off shifting until the last read has been compared.
        DRAIN: begin
          if (cnt == 5'(READ_LAT - 1)) begin
            state  <= SHIFT;
            srl_ce <= 1'b1;
            cnt    <= 5'd0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        SHIFT: begin
          if (cnt == 5'(SHIFT_LEN - 1)) begin
            state     <= IDLE;
            srl_ce    <= 1'b0;
            pass_done <= 1'b1;
            pass_cnt  <= pass_cnt + 8'd1;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: data-path storage (addresses, shadow, LFSR) is deliberately left without reset.
  always_ff @(posedge clk) begin
    addr_pipe[0] <= issue_a;
    for (int k = 1; k < READ_LAT; k++) addr_pipe[k] <= addr_pipe[k-1];
  end

  // Shadow shifts on exactly the edges the real SRLs do; bit 31 falls off the end.
  always_ff @(posedge clk) begin
    if (srl_ce) begin
      for (int i = 0; i < NUM_SRL; i++) shadow[i] <= {shadow[i][30:0], srl_d[i]};
      lfsr <= {lfsr[14:0], fb};
    end
  end

endmodule

// File: tb/tb_srl_seq_checker.sv
// Directed bench: behavioural SRL32 lanes around two checker instances
// (combinational read, READ_LAT=1; registered read, READ_LAT=2).
module tb_srl_seq_checker;

  localparam int         N    = 8;
  localparam logic [255:0] INIT = {8{32'h5A5A_C3C3}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, en, srl_ce, pass_done, inv3;
  logic [N-1:0] srl_d, srl_q, error;
  logic [4:0]   srl_a;
  logic [7:0]   pass_cnt;

  logic         rst2_n, en2, srl_ce2, pass_done2;
  logic [N-1:0] srl_d2, srl_q2, error2;
  logic [4:0]   srl_a2;
  logic [7:0]   pass_cnt2;

  srl_seq_checker #(.NUM_SRL(N), .INIT_VEC(INIT), .READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .srl_ce(srl_ce), .srl_d(srl_d),
    .srl_a(srl_a), .srl_q(srl_q), .error(error), .pass_done(pass_done),
    .pass_cnt(pass_cnt));

  srl_seq_checker #(.NUM_SRL(N), .INIT_VEC(INIT), .READ_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .srl_ce(srl_ce2), .srl_d(srl_d2),
    .srl_a(srl_a2), .srl_q(srl_q2), .error(error2), .pass_done(pass_done2),
    .pass_cnt(pass_cnt2));

  // Behavioural SRL32 lanes (no reset, INIT contents at power-up)
  logic [31:0] mem1 [N];
  logic [31:0] mem2 [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      mem1[i] = INIT[32*i +: 32];
      mem2[i] = INIT[32*i +: 32];
    end
  end

  always @(posedge clk) begin
    if (srl_ce)  for (int i = 0; i < N; i++) mem1[i] <= {mem1[i][30:0], srl_d[i]};
    if (srl_ce2) for (int i = 0; i < N; i++) mem2[i] <= {mem2[i][30:0], srl_d2[i]};
    for (int i = 0; i < N; i++) srl_q2[i] <= mem2[i][srl_a2];
  end

  always_comb begin
    srl_q = '0;
    for (int i = 0; i < N; i++) srl_q[i] = mem1[i][srl_a] ^ (inv3 && (i == 3));
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor for the READ_LAT=2 instance: error accumulation, pass spacing, counter wrap
  int         cyc_n      = 0;
  int         last_done2 = -1;
  int         interval2  = 0;
  logic [7:0] err2_acc   = '0;
  logic [7:0] prev_cnt2  = '0;
  logic       seen2      = 1'b0;
  logic       wrap_seen  = 1'b0;
  logic [7:0] wrap_val   = 8'hxx;

  always @(negedge clk) begin
    cyc_n++;
    if (rst2_n === 1'b1) begin
      err2_acc |= error2;
      if (pass_done2) begin
        if (last_done2 >= 0) interval2 = cyc_n - last_done2;
        last_done2 = cyc_n;
        if (seen2 && prev_cnt2 == 8'hFF) begin
          wrap_seen = 1'b1;
          wrap_val  = pass_cnt2;
        end
        prev_cnt2 = pass_cnt2;
        seen2     = 1'b1;
      end
    end
  end

  typedef struct {
    int         cyc;
    logic       ce;
    logic [4:0] a;
    logic       chk_a;
    logic [7:0] d;
    logic       chk_d;
    logic       done;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [12];

  // Runs until pass_cnt equals target, checking error every cycle and counting pulses.
  task automatic run_until_cnt(input logic [7:0] target, input logic [7:0] exp_err,
                               input logic [7:0] start);
    int   ndone = 0;
    logic hit   = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      check("error_hold", error, exp_err);
      if (pass_done) ndone++;
      if (pass_cnt == target) begin
        hit = 1'b1;
        break;
      end
    end
    check("pass_reached", hit, 1);
    check("pass_done_pulses", ndone, 32'(target - start));
  endtask

  initial begin
    int   idx;
    logic hit;

    // cycle 0 = IDLE cycle right after reset release with en=1
    tbl[0]  = '{0,  1'b0, 5'd0,  1'b1, 8'hE1, 1'b1, 1'b0, 8'd0};
    tbl[1]  = '{1,  1'b0, 5'd0,  1'b1, 8'h00, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{2,  1'b0, 5'd1,  1'b1, 8'h00, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{10, 1'b0, 5'd9,  1'b1, 8'h00, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{17, 1'b0, 5'd16, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{32, 1'b0, 5'd31, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{33, 1'b0, 5'd31, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{34, 1'b1, 5'd0,  1'b0, 8'hE1, 1'b1, 1'b0, 8'd0};
    tbl[8]  = '{35, 1'b1, 5'd0,  1'b0, 8'hC3, 1'b1, 1'b0, 8'd0};
    tbl[9]  = '{40, 1'b1, 5'd0,  1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    tbl[10] = '{41, 1'b0, 5'd0,  1'b0, 8'h00, 1'b0, 1'b1, 8'd1};
    tbl[11] = '{42, 1'b0, 5'd0,  1'b1, 8'h00, 1'b0, 1'b0, 8'd1};

    rst_n = 1'b0; en = 1'b0; inv3 = 1'b0;
    rst2_n = 1'b0; en2 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ce", srl_ce, 0);
    check("rst_a", srl_a, 0);
    check("rst_error", error, 0);
    check("rst_done", pass_done, 0);
    check("rst_cnt", pass_cnt, 0);

    rst_n = 1'b1; en = 1'b1;
    rst2_n = 1'b1; en2 = 1'b1;

    // First pass, cycle-by-cycle against the table
    idx = 0;
    for (int cyc = 0; cyc <= 42; cyc++) begin
      if (idx < 12 && tbl[idx].cyc == cyc) begin
        check($sformatf("c%0d_ce", cyc), srl_ce, tbl[idx].ce);
        if (tbl[idx].chk_a) check($sformatf("c%0d_a", cyc), srl_a, tbl[idx].a);
        if (tbl[idx].chk_d) check($sformatf("c%0d_d", cyc), srl_d, tbl[idx].d);
        check($sformatf("c%0d_done", cyc), pass_done, tbl[idx].done);
        check($sformatf("c%0d_cnt", cyc), pass_cnt, tbl[idx].cnt);
        check($sformatf("c%0d_error", cyc), error, 0);
        idx++;
      end
      if (cyc < 42) @(negedge clk);
    end

    // Fault on lane 3 at CHECK address 5 (pass 2, cycle 47)
    repeat (5) @(negedge clk);
    check("fault_addr", srl_a, 5);
    check("fault_pre_error", error, 0);
    inv3 = 1'b1;
    @(negedge clk);
    inv3 = 1'b0;
    check("fault_error", error, 8'h08);
    run_until_cnt(8'd4, 8'h08, 8'd1);

    // Reset in the 3rd SHIFT cycle of pass 5
    hit = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (srl_ce) begin
        hit = 1'b1;
        break;
      end
    end
    check("shift_seen", hit, 1);
    repeat (2) @(negedge clk);
    check("shift3_ce", srl_ce, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ce", srl_ce, 0);
    check("midrst_a", srl_a, 0);
    check("midrst_error", error, 0);
    check("midrst_done", pass_done, 0);
    check("midrst_cnt", pass_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_cnt", pass_cnt, 0);
    run_until_cnt(8'd3, 8'h00, 8'd0);

    // en low after reset: stay in IDLE until en rises
    @(negedge clk);
    en = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_ce", srl_ce, 0);
      check("idle_cnt", pass_cnt, 0);
      check("idle_a", srl_a, 0);
    end
    en = 1'b1;
    @(negedge clk);
    check("en_check_a0", srl_a, 0);
    @(negedge clk);
    check("en_check_a1", srl_a, 1);
    check("en_check_ce", srl_ce, 0);
    run_until_cnt(8'd1, 8'h00, 8'd0);

    // READ_LAT=2 instance: run on through the 255->0 wrap of pass_cnt
    for (int k = 0; k < 12000; k++) begin
      if (wrap_seen) break;
      @(negedge clk);
    end
    check("rl2_wrap_seen", wrap_seen, 1);
    check("rl2_wrap_val", wrap_val, 0);
    check("rl2_error", err2_acc, 0);
    check("rl2_pass_len", interval2, 42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
